// File: rtl/prog_pkg.sv
// Shared constants for the programming-mode editor: FSM states, mode codes
// and the BCD range limits of every editable field.
package prog_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EDIT_FECHA,
        S_EDIT_HORA,
        S_EDIT_TIMER,
        S_COMMIT
    } state_t;

    localparam logic [2:0] MODE_NONE  = 3'b000;
    localparam logic [2:0] MODE_FECHA = 3'b001;
    localparam logic [2:0] MODE_HORA  = 3'b010;
    localparam logic [2:0] MODE_TIMER = 3'b100;

    localparam logic [7:0] BCD_ZERO = 8'h00;
    localparam logic [7:0] HORA_MAX = 8'h23;
    localparam logic [7:0] MS_MAX   = 8'h59;
    localparam logic [7:0] DIA_MIN  = 8'h01;
    localparam logic [7:0] DIA_MAX  = 8'h31;
    localparam logic [7:0] MES_MIN  = 8'h01;
    localparam logic [7:0] MES_MAX  = 8'h12;
    localparam logic [7:0] ANIO_MAX = 8'h99;

    // Mode code of the group an EDIT state works on; MODE_NONE elsewhere.
    function automatic logic [2:0] mode_of(input state_t s);
        case (s)
            S_EDIT_FECHA: mode_of = MODE_FECHA;
            S_EDIT_HORA:  mode_of = MODE_HORA;
            S_EDIT_TIMER: mode_of = MODE_TIMER;
            default:      mode_of = MODE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/bcd_step.sv
// Combinational two-digit BCD increment/decrement with wrap between min and max.
module bcd_step (
    input  logic [7:0] value,
    input  logic [7:0] min,
    input  logic [7:0] max,
    input  logic       up,
    input  logic       down,
    output logic [7:0] next
);
    always_comb begin
        next = value;
        if (up) begin
            if (value == max)
                next = min;
            else if (value[3:0] == 4'd9)
                next = {value[7:4] + 4'd1, 4'd0};
            else
                next = value + 8'd1;
        end else if (down) begin
            if (value == min)
                next = max;
            else if (value[3:0] == 4'd0)
                next = {value[7:4] - 4'd1, 4'd9};
            else
                next = value - 8'd1;
        end
    end
endmodule

// File: rtl/prog_editor.sv
// Edit controller: selects and steps time/date/timer BCD fields from button
// edges and pulses a commit strobe when a programming mode is left.
module prog_editor
    import prog_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] prog,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic [7:0] hora,
    output logic [7:0] min,
    output logic [7:0] seg,
    output logic [7:0] dia,
    output logic [7:0] mes,
    output logic [7:0] anio,
    output logic [7:0] t_hora,
    output logic [7:0] t_min,
    output logic [7:0] t_seg,
    output logic [1:0] cursor,
    output logic       editing,
    output logic       wr_strobe,
    output logic [2:0] wr_sel
);
    state_t     state_q;
    logic [3:0] btn_q;
    logic [7:0] hora_q, min_q, seg_q, dia_q, mes_q, anio_q;
    logic [7:0] t_hora_q, t_min_q, t_seg_q;
    logic [1:0] cursor_q;
    logic       editing_q, wr_strobe_q;
    logic [2:0] wr_sel_q;

    logic [3:0] btn_now, btn_edge;
    logic       act_up, act_down, act_left, act_right;
    logic [2:0] grp;
    logic [7:0] cur_val, cur_min, cur_max, step_d;

    assign btn_now   = {btn_up, btn_down, btn_left, btn_right};
    assign btn_edge  = btn_now & ~btn_q;
    assign act_up    = btn_edge[3];
    assign act_down  = btn_edge[2] & ~btn_edge[3];
    assign act_left  = btn_edge[1] & ~|btn_edge[3:2];
    assign act_right = btn_edge[0] & ~|btn_edge[3:1];
    assign grp       = mode_of(state_q);

    always_comb begin
        cur_val = '0;
        cur_min = BCD_ZERO;
        cur_max = BCD_ZERO;
        case (state_q)
            S_EDIT_FECHA:
                case (cursor_q)
                    2'd0:    begin cur_val = dia_q;  cur_min = DIA_MIN; cur_max = DIA_MAX;  end
                    2'd1:    begin cur_val = mes_q;  cur_min = MES_MIN; cur_max = MES_MAX;  end
                    default: begin cur_val = anio_q; cur_max = ANIO_MAX; end
                endcase
            S_EDIT_HORA:
                case (cursor_q)
                    2'd0:    begin cur_val = hora_q; cur_max = HORA_MAX; end
                    2'd1:    begin cur_val = min_q;  cur_max = MS_MAX;   end
                    default: begin cur_val = seg_q;  cur_max = MS_MAX;   end
                endcase
            S_EDIT_TIMER:
                case (cursor_q)
                    2'd0:    begin cur_val = t_hora_q; cur_max = HORA_MAX; end
                    2'd1:    begin cur_val = t_min_q;  cur_max = MS_MAX;   end
                    default: begin cur_val = t_seg_q;  cur_max = MS_MAX;   end
                endcase
            default: ;
        endcase
    end

    bcd_step u_step (
        .value (cur_val),
        .min   (cur_min),
        .max   (cur_max),
        .up    (act_up),
        .down  (act_down),
        .next  (step_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            btn_q       <= '0;
            hora_q      <= BCD_ZERO;
            min_q       <= BCD_ZERO;
            seg_q       <= BCD_ZERO;
            dia_q       <= DIA_MIN;
            mes_q       <= MES_MIN;
            anio_q      <= BCD_ZERO;
            t_hora_q    <= BCD_ZERO;
            t_min_q     <= BCD_ZERO;
            t_seg_q     <= BCD_ZERO;
            cursor_q    <= '0;
            editing_q   <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_sel_q    <= '0;
        end else begin
            btn_q       <= btn_now;
            wr_strobe_q <= 1'b0;
            wr_sel_q    <= '0;

            // Actions apply in every EDIT state, including the cycle that leaves it.
            if (grp != MODE_NONE) begin
                if (act_left)
                    cursor_q <= (cursor_q == 2'd0) ? 2'd2 : cursor_q - 2'd1;
                else if (act_right)
                    cursor_q <= (cursor_q == 2'd2) ? 2'd0 : cursor_q + 2'd1;
                if (act_up || act_down) begin
                    case (state_q)
                        S_EDIT_FECHA:
                            case (cursor_q)
                                2'd0:    dia_q  <= step_d;
                                2'd1:    mes_q  <= step_d;
                                default: anio_q <= step_d;
                            endcase
                        S_EDIT_HORA:
                            case (cursor_q)
                                2'd0:    hora_q <= step_d;
                                2'd1:    min_q  <= step_d;
                                default: seg_q  <= step_d;
                            endcase
                        default:
                            case (cursor_q)
                                2'd0:    t_hora_q <= step_d;
                                2'd1:    t_min_q  <= step_d;
                                default: t_seg_q  <= step_d;
                            endcase
                    endcase
                end
                if (prog != grp) begin
                    state_q     <= S_COMMIT;
                    editing_q   <= 1'b0;
                    wr_strobe_q <= 1'b1;
                    wr_sel_q    <= grp;
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (prog == MODE_FECHA || prog == MODE_HORA || prog == MODE_TIMER) begin
                            state_q   <= (prog == MODE_FECHA) ? S_EDIT_FECHA :
                                         (prog == MODE_HORA)  ? S_EDIT_HORA  : S_EDIT_TIMER;
                            editing_q <= 1'b1;
                            cursor_q  <= '0;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign hora      = hora_q;
    assign min       = min_q;
    assign seg       = seg_q;
    assign dia       = dia_q;
    assign mes       = mes_q;
    assign anio      = anio_q;
    assign t_hora    = t_hora_q;
    assign t_min     = t_min_q;
    assign t_seg     = t_seg_q;
    assign cursor    = cursor_q;
    assign editing   = editing_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_sel    = wr_sel_q;
endmodule

// File: tb/tb_prog_editor.sv
// Directed bench for prog_editor: field stepping, wrap, BCD carry, commit
// strobe timing, button priority and asynchronous reset.
module tb_prog_editor;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] prog = 3'b000;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic [7:0] hora, min, seg, dia, mes, anio, t_hora, t_min, t_seg;
    logic [1:0] cursor;
    logic       editing, wr_strobe;
    logic [2:0] wr_sel;

    int checks = 0;
    int errors = 0;

    localparam logic [3:0] B_UP = 4'b1000, B_DN = 4'b0100, B_LT = 4'b0010, B_RT = 4'b0001;

    prog_editor dut (
        .clk(clk), .reset(reset), .prog(prog),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .hora(hora), .min(min), .seg(seg), .dia(dia), .mes(mes), .anio(anio),
        .t_hora(t_hora), .t_min(t_min), .t_seg(t_seg),
        .cursor(cursor), .editing(editing), .wr_strobe(wr_strobe), .wr_sel(wr_sel)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btns(input logic [3:0] m);
        {btn_up, btn_down, btn_left, btn_right} = m;
    endtask

    task automatic press(input logic [3:0] m, input int n);
        for (int i = 0; i < n; i++) begin
            set_btns(m);
            tick();
            set_btns(4'b0000);
            tick();
        end
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_eq("rst_hora", hora, 8'h00);
        check_eq("rst_dia", dia, 8'h01);
        check_eq("rst_mes", mes, 8'h01);
        check_eq("rst_tseg", t_seg, 8'h00);
        check_eq("rst_strobe", wr_strobe, 1'b0);
        check_eq("rst_editing", editing, 1'b0);
        check_eq("rst_wrsel", wr_sel, 3'b000);

        // Time mode
        prog = 3'b010;
        tick();
        check_eq("enter_hora_editing", editing, 1'b1);
        check_eq("enter_hora_cursor", cursor, 2'd0);
        press(B_UP, 1);
        check_eq("hora_up", hora, 8'h01);
        press(B_RT, 1);
        check_eq("cursor_right", cursor, 2'd1);
        press(B_DN, 10);
        check_eq("min_10_down", min, 8'h50);
        set_btns(B_UP);
        for (int i = 0; i < 20; i++) tick();
        set_btns(4'b0000);
        tick();
        check_eq("hold_one_inc", min, 8'h51);
        press(B_UP, 8);
        check_eq("min_59", min, 8'h59);
        press(B_UP, 1);
        check_eq("min_wrap", min, 8'h00);
        press(B_UP, 9);
        check_eq("min_09", min, 8'h09);
        press(B_UP, 1);
        check_eq("bcd_carry", min, 8'h10);
        press(B_DN, 1);
        check_eq("bcd_borrow", min, 8'h09);
        press(B_RT, 1);
        press(B_DN, 1);
        check_eq("seg_down_wrap", seg, 8'h59);
        press(B_UP, 1);
        check_eq("seg_up_wrap", seg, 8'h00);
        press(B_RT, 1);
        check_eq("cursor_right_wrap", cursor, 2'd0);
        press(B_LT, 1);
        check_eq("cursor_left_wrap", cursor, 2'd2);
        press(B_RT, 1);
        press(B_DN, 2);
        check_eq("hora_down_wrap", hora, 8'h23);
        press(B_UP, 1);
        check_eq("hora_up_wrap", hora, 8'h00);
        check_eq("min_held", min, 8'h09);

        prog = 3'b000;
        tick();
        check_eq("hora_commit_strobe", wr_strobe, 1'b1);
        check_eq("hora_commit_sel", wr_sel, 3'b010);
        tick();
        check_eq("strobe_one_cycle", wr_strobe, 1'b0);
        check_eq("wrsel_cleared", wr_sel, 3'b000);

        // Date mode
        prog = 3'b001;
        tick();
        check_eq("enter_fecha", editing, 1'b1);
        press(B_DN, 1);
        check_eq("dia_down_wrap", dia, 8'h31);
        press(B_UP, 1);
        check_eq("dia_up_wrap", dia, 8'h01);
        press(B_RT, 1);
        press(B_DN, 1);
        check_eq("mes_down_wrap", mes, 8'h12);
        press(B_RT, 1);
        press(B_DN, 1);
        check_eq("anio_99", anio, 8'h99);
        press(B_UP, 1);
        check_eq("anio_wrap", anio, 8'h00);
        check_eq("hora_untouched", hora, 8'h00);

        // Direct change date -> time
        prog = 3'b010;
        tick();
        check_eq("direct_strobe", wr_strobe, 1'b1);
        check_eq("direct_sel", wr_sel, 3'b001);
        check_eq("direct_commit_editing", editing, 1'b0);
        tick();
        check_eq("direct_idle_editing", editing, 1'b0);
        tick();
        check_eq("direct_reenter", editing, 1'b1);
        check_eq("direct_cursor0", cursor, 2'd0);
        prog = 3'b000;
        tick();
        tick();

        // Timer mode: simultaneous edges, then edge on the leaving cycle
        prog = 3'b100;
        tick();
        press(B_RT, 2);
        check_eq("timer_cursor", cursor, 2'd2);
        press(B_UP | B_RT, 1);
        check_eq("simul_field", t_seg, 8'h01);
        check_eq("simul_cursor", cursor, 2'd2);
        set_btns(B_UP);
        prog = 3'b000;
        tick();
        set_btns(4'b0000);
        check_eq("leave_edge_applied", t_seg, 8'h02);
        check_eq("timer_strobe", wr_strobe, 1'b1);
        check_eq("timer_sel", wr_sel, 3'b100);
        tick();
        check_eq("timer_strobe_off", wr_strobe, 1'b0);

        // Buttons with no mode
        press(B_UP, 1);
        press(B_DN, 1);
        press(B_LT, 1);
        check_eq("idle_tseg", t_seg, 8'h02);
        check_eq("idle_hora", hora, 8'h00);
        check_eq("idle_cursor", cursor, 2'd2);
        check_eq("idle_editing", editing, 1'b0);

        // Asynchronous reset mid-edit
        prog = 3'b010;
        tick();
        press(B_UP, 1);
        check_eq("pre_reset_hora", hora, 8'h01);
        #2;
        reset = 1'b1;
        #1;
        check_eq("async_hora", hora, 8'h00);
        check_eq("async_min", min, 8'h00);
        check_eq("async_anio", anio, 8'h00);
        check_eq("async_dia", dia, 8'h01);
        check_eq("async_mes", mes, 8'h01);
        check_eq("async_tseg", t_seg, 8'h00);
        check_eq("async_editing", editing, 1'b0);
        check_eq("async_strobe", wr_strobe, 1'b0);
        check_eq("async_cursor", cursor, 2'd0);
        prog = 3'b000;
        tick();
        reset = 1'b0;
        tick();
        check_eq("post_reset_strobe", wr_strobe, 1'b0);
        tick();
        check_eq("post_reset_strobe2", wr_strobe, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
